// File: rtl/lut4_sweep_pkg.sv
// Shared types and sizes for the 4-to-4 truth-table sweep controller.
//   sweep_state_e : controller FSM states
//   VEC_COUNT     : number of input codes swept (2**CODE_W)
//   CODE_W        : width of one input/output code
//   ERR_W         : mismatch counter width (must hold VEC_COUNT itself)
//   LAST_CODE     : highest input code, ends the sweep
package lut4_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_e;

    localparam int unsigned VEC_COUNT = 16;
    localparam int unsigned CODE_W    = 4;
    localparam int unsigned ERR_W     = 5;

    localparam logic [CODE_W-1:0] LAST_CODE = 4'hF;

endpackage

// File: rtl/lut4_golden_ram.sv
// 16 x 4 golden-result register file.
// Ports:
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset, clears every entry to zero
//   wr_en    : write request
//   wr_block : suppresses wr_en (held high while a sweep runs)
//   wr_addr  : entry to write
//   wr_data  : value to write
//   rd_addr  : entry to read (combinational read)
//   rd_data  : contents of rd_addr
module lut4_golden_ram
    import lut4_sweep_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              wr_block,
    input  logic [CODE_W-1:0] wr_addr,
    input  logic [CODE_W-1:0] wr_data,
    input  logic [CODE_W-1:0] rd_addr,
    output logic [CODE_W-1:0] rd_data
);

    logic [CODE_W-1:0] mem_q [VEC_COUNT];
    logic [CODE_W-1:0] mem_d [VEC_COUNT];
    logic              wr_fire_s;

    assign wr_fire_s = wr_en & ~wr_block;

    // Next-state of the table: copy, then overlay the single permitted write.
    always_comb begin
        for (int i = 0; i < VEC_COUNT; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_fire_s) begin
            mem_d[wr_addr] = wr_data;
        end else begin
            mem_d[wr_addr] = mem_q[wr_addr];
        end
    end

    // Table storage with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < VEC_COUNT; i++) begin
                mem_q[i] <= 4'h0;
            end
        end else begin
            for (int i = 0; i < VEC_COUNT; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/lut4_sweep_controller.sv
// Sweeps all 16 input codes through an external combinational 4-to-4 unit,
// compares each settled result with a programmable golden table and reports
// the outcome.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   start            : begin a sweep (honoured only in IDLE or DONE)
//   abort            : drop any sweep and return to IDLE with cleared results
//   cfg_we/addr/data : golden-table write port (ignored while busy)
//   x_out            : code driven to the unit under control
//   y_in             : result returned by the unit under control
//   busy             : sweep in progress
//   done             : sweep finished, held until next start or abort
//   pass             : valid with done, high when no mismatch was seen
//   err_cnt          : number of mismatching codes, 0..16
//   first_err_valid  : at least one mismatch recorded
//   first_err_idx    : lowest mismatching code
module lut4_sweep_controller
    import lut4_sweep_pkg::*;
#(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned W      = 4
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             cfg_we,
    input  logic [W-1:0]     cfg_addr,
    input  logic [W-1:0]     cfg_data,
    output logic [W-1:0]     x_out,
    input  logic [W-1:0]     y_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             first_err_valid,
    output logic [W-1:0]     first_err_idx
);

    // WAIT runs from the reload value down to zero inclusive, i.e. SETTLE cycles.
    localparam logic [3:0] CNT_RELOAD = 4'(SETTLE - 1);

    sweep_state_e      state_q, state_d;
    logic [CODE_W-1:0] idx_q, idx_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [CODE_W-1:0] x_out_q, x_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              fev_q, fev_d;
    logic [CODE_W-1:0] fei_q, fei_d;

    logic [CODE_W-1:0] golden_s;
    logic              mismatch_s;
    logic [ERR_W-1:0]  err_sum_s;

    lut4_golden_ram u_golden (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (cfg_we),
        .wr_block (busy_q),
        .wr_addr  (cfg_addr),
        .wr_data  (cfg_data),
        .rd_addr  (idx_q),
        .rd_data  (golden_s)
    );

    assign mismatch_s = (y_in != golden_s);
    // At most 16 increments follow each clear, so the 5-bit sum cannot wrap.
    assign err_sum_s  = err_cnt_q + ERR_W'(mismatch_s);

    // Next-state and output logic of the sweep FSM.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        x_out_d   = x_out_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        err_cnt_d = err_cnt_q;
        fev_d     = fev_q;
        fei_d     = fei_q;

        if (abort) begin
            state_d   = IDLE;
            idx_d     = 4'h0;
            cnt_d     = 4'h0;
            x_out_d   = 4'h0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            pass_d    = 1'b0;
            err_cnt_d = 5'd0;
            fev_d     = 1'b0;
            fei_d     = 4'h0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d   = WAIT;
                        idx_d     = 4'h0;
                        cnt_d     = CNT_RELOAD;
                        x_out_d   = 4'h0;
                        busy_d    = 1'b1;
                        done_d    = 1'b0;
                        pass_d    = 1'b0;
                        err_cnt_d = 5'd0;
                        fev_d     = 1'b0;
                        fei_d     = 4'h0;
                    end else begin
                        state_d = state_q;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_d = SAMPLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                SAMPLE: begin
                    err_cnt_d = err_sum_s;
                    if (mismatch_s && !fev_q) begin
                        fev_d = 1'b1;
                        fei_d = idx_q;
                    end else begin
                        fev_d = fev_q;
                        fei_d = fei_q;
                    end
                    if (idx_q == LAST_CODE) begin
                        // x_out keeps driving the last code while results are held.
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_sum_s == 5'd0);
                    end else begin
                        state_d = WAIT;
                        idx_d   = idx_q + 4'd1;
                        x_out_d = idx_q + 4'd1;
                        cnt_d   = CNT_RELOAD;
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            endcase
        end
    end

    // Controller state registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= 4'h0;
            cnt_q     <= 4'h0;
            x_out_q   <= 4'h0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_cnt_q <= 5'd0;
            fev_q     <= 1'b0;
            fei_q     <= 4'h0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            x_out_q   <= x_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_cnt_q <= err_cnt_d;
            fev_q     <= fev_d;
            fei_q     <= fei_d;
        end
    end

    assign x_out           = x_out_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_cnt         = err_cnt_q;
    assign first_err_valid = fev_q;
    assign first_err_idx   = fei_q;

endmodule

// File: doc/lut4_sweep_controller.md
Name: lut4_sweep_controller

Overview:
Sequencer for the team's 4-input/4-output combinational truth-table units.
- On a start pulse, drives all 16 input codes in ascending order onto the unit under control.
- Waits a programmable settle time per code, samples the 4-bit result and compares it against a programmable 16-entry golden table.
- Reports pass/fail, mismatch count and the first failing code.
- Sits between a host/config interface and one combinational 4-to-4 block in hardware self-check builds.

Parameters:
- SETTLE, 2, clock cycles between driving a code and sampling the result (legal range 1..15).
- W, 4, input/output code width; fixed at 4; 2**W = 16 vectors.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a sweep; sampled in IDLE or DONE only
- abort  in  1  terminate a sweep; returns to IDLE
- cfg_we  in  1  golden-table write enable
- cfg_addr  in  4  golden-table index (input code)
- cfg_data  in  4  expected result for cfg_addr
- x_out  out  4  code driven to the combinational unit ({x3,x2,x1,x0})
- y_in  in  4  result from the combinational unit ({y3,y2,y1,y0})
- busy  out  1  sweep in progress
- done  out  1  sweep completed; held until next start or abort
- pass  out  1  valid when done; 1 iff err_cnt == 0
- err_cnt  out  5  mismatch count, 0..16
- first_err_valid  out  1  at least one mismatch recorded
- first_err_idx  out  4  lowest code that mismatched

Behaviour:
- Single clock; rst_n is asynchronous and active-low. All registers are set asynchronously when rst_n=0 and released synchronously on clk.
- Reset values: x_out=0, busy=0, done=0, pass=0, err_cnt=0, first_err_valid=0, first_err_idx=0, all golden entries=0, state=IDLE.
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE/DONE + start=1 (abort=0):
  - idx<=0, x_out<=0, settle counter<=SETTLE-1.
  - err_cnt, first_err_valid, first_err_idx and done cleared.
  - busy<=1; next state WAIT.
- WAIT: counter decrements each cycle; at 0 go to SAMPLE. WAIT lasts exactly SETTLE cycles.
- SAMPLE (1 cycle):
  - If y_in != golden[idx]: err_cnt++. If first_err_valid=0, also set first_err_idx<=idx and first_err_valid<=1.
  - If idx==15: go to DONE with busy<=0, done<=1, pass<=(final err_cnt==0); x_out holds 15.
  - Else: idx++, x_out<=idx+1, counter reloaded, go to WAIT.
- Timing:
  - Each code is held on x_out for exactly SETTLE+1 cycles.
  - done rises 16*(SETTLE+1) clocks after the edge that samples start; 48 for SETTLE=2.
- abort=1 in any state: next state IDLE, x_out<=0, busy<=0, done<=0, pass<=0; err_cnt and first_err fields cleared. abort and start in the same cycle: abort wins.
- start while busy: ignored.
- cfg_we while busy: ignored, table unchanged. When not busy, the write takes effect at the clock edge.
- Golden table reads are combinational from idx.
- cfg_we and start in the same IDLE cycle: the write completes, and the write to entry 0 is visible at the first SAMPLE.
- err_cnt never wraps; maximum value 16 needs 5 bits.
- rst_n asserted mid-sweep: immediate return to reset values, including golden table cleared.

Decomposition:
- Package lut4_sweep_pkg:
  - state enum {IDLE, WAIT, SAMPLE, DONE}
  - VEC_COUNT=16, CODE_W=4, ERR_W=5
- Sub-module lut4_golden_ram: 16x4 register file, synchronous write with write-gating input, asynchronous read, async active-low reset to zero.
- FSM, counters and comparison live in lut4_sweep_controller.

Test Plan:
- Identity model (y_in=x_out); program golden[i]=i; pulse start -> busy for 48 cycles, done=1, pass=1, err_cnt=0, first_err_valid=0; x_out steps 0..15 with each value held 3 cycles.
- Inverting model (y_in=~x_out); golden[i]=i -> done, pass=0, err_cnt=16, first_err_idx=0.
- Identity model; golden[i]=i except golden[5]=4'hA and golden[12]=4'h0 -> err_cnt=2, first_err_idx=5, pass=0.
- abort at cycle 20 of a sweep -> next cycle state IDLE, busy=0, done=0, x_out=0, err_cnt=0. New start afterwards completes normally with done at cycle 48.
- cfg_we to addr 3 with data 4'hF during busy, then rerun identity sweep -> pass=1, confirming the write was ignored. Also: start asserted during busy causes no restart (done still at cycle 48 from the original start).
- rst_n pulsed low asynchronously mid-SAMPLE -> all outputs at reset values before the next clk edge; golden table reads 0 afterwards.
